// File: rtl/ofc_pkg.sv
`default_nettype none
// ============================================================================
// ofc_pkg: shared types and constants for the OFC capture sequencer.
// Revision: 1.0
// ============================================================================
package ofc_pkg;

   localparam int OFC_NSAMP = 5;
   localparam int OFC_IDX_W = 3;
   localparam int OFC_RES_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_BURST   = 3'd3,
      ST_LATCH   = 3'd4,
      ST_HANDOFF = 3'd5,
      ST_HOLDOFF = 3'd6
   } ofc_seq_state_t;

   function automatic logic is_busy(input ofc_seq_state_t s);
      return (s != ST_IDLE) && (s != ST_ARMED);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ofc_holdoff_timer.sv
`default_nettype none
// ============================================================================
// ofc_holdoff_timer: loadable down-counter that stops at zero.
// Revision: 1.0
// ============================================================================
module ofc_holdoff_timer #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count_en,
   output logic             zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count_en && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/ofc_capture_sequencer.sv
`default_nettype none
// ============================================================================
// ofc_capture_sequencer: threshold trigger, 5-sample capture, gap-free burst
// replay to the OFC multiplier and valid/ready handoff of the pulse height.
// Revision: 1.0
// ============================================================================
module ofc_capture_sequencer
   import ofc_pkg::*;
#(
   parameter int DATA_W         = 14,
   parameter int HOLDOFF_CYCLES = 64,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DATA_W-1:0]    threshold,
   input  logic [DATA_W-1:0]    adc_data,
   input  logic                 adc_valid,
   output logic [DATA_W-1:0]    ofc_data,
   output logic [OFC_IDX_W-1:0] ofc_sample,
   input  logic [OFC_RES_W-1:0] pulse_height,
   output logic [OFC_RES_W-1:0] result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 busy,
   output logic [CNT_W-1:0]     missed_count
);

   localparam int                   HOLD_W    = $clog2(HOLDOFF_CYCLES) + 1;
   localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [OFC_IDX_W-1:0] IDX_ONE   = OFC_IDX_W'(1);
   localparam logic [OFC_IDX_W-1:0] IDX_CAP0  = OFC_IDX_W'(2);
   localparam logic [OFC_IDX_W-1:0] IDX_LAST  = OFC_IDX_W'(OFC_NSAMP - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

   ofc_seq_state_t state;
   ofc_seq_state_t next_state;

   logic [DATA_W-1:0]    cap_buf [OFC_NSAMP];
   logic [OFC_IDX_W-1:0] idx;
   logic [DATA_W-1:0]    prev_sample;
   logic                 prev_ok;

   logic above_thr;
   logic trigger;
   logic cap_beat;
   logic cap_last;
   logic burst_last;
   logic accept;
   logic hold_zero;

   assign above_thr  = (adc_data > threshold);
   assign trigger    = (state == ST_ARMED) && enable && adc_valid && prev_ok && above_thr;
   assign cap_beat   = (state == ST_CAPTURE) && enable && adc_valid;
   assign cap_last   = cap_beat && (idx == IDX_LAST);
   assign burst_last = (state == ST_BURST) && (idx == IDX_LAST);
   assign accept     = (state == ST_HANDOFF) && result_ready;

   ofc_holdoff_timer #(
      .WIDTH (HOLD_W)
   ) u_holdoff (
      .clk        (clk),
      .reset      (reset),
      .load       (accept),
      .load_value (HOLD_LOAD),
      .count_en   (state == ST_HOLDOFF),
      .zero       (hold_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Once the burst starts it always runs to handoff, so enable only aborts before it.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (enable) next_state = ST_ARMED;
         ST_ARMED: begin
            if (!enable)      next_state = ST_IDLE;
            else if (trigger) next_state = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (!enable)       next_state = ST_IDLE;
            else if (cap_last) next_state = ST_BURST;
         end
         ST_BURST:   if (burst_last) next_state = ST_LATCH;
         ST_LATCH:   next_state = ST_HANDOFF;
         ST_HANDOFF: if (result_ready) next_state = ST_HOLDOFF;
         ST_HOLDOFF: if (hold_zero) next_state = enable ? ST_ARMED : ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      ofc_sample = '0;
      ofc_data   = '0;
      if (state == ST_BURST) begin
         ofc_sample = idx + IDX_ONE;
         ofc_data   = cap_buf[idx];
      end
      busy = is_busy(state);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < OFC_NSAMP; i++) begin
            cap_buf[i] <= '0;
         end
         idx          <= '0;
         prev_sample  <= '0;
         prev_ok      <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         // The pedestal is only trusted once a valid beat has been seen since arming.
         if (state != ST_ARMED) begin
            prev_ok <= 1'b0;
         end else if (adc_valid) begin
            prev_sample <= adc_data;
            prev_ok     <= 1'b1;
         end

         case (state)
            ST_ARMED: begin
               if (trigger) begin
                  cap_buf[0] <= prev_sample;
                  cap_buf[1] <= adc_data;
                  idx        <= IDX_CAP0;
               end
            end
            ST_CAPTURE: begin
               if (cap_beat) begin
                  cap_buf[idx] <= adc_data;
                  idx          <= cap_last ? '0 : idx + IDX_ONE;
               end
            end
            ST_BURST: begin
               idx <= burst_last ? '0 : idx + IDX_ONE;
            end
            ST_LATCH: begin
               result       <= pulse_height;
               result_valid <= 1'b1;
            end
            ST_HANDOFF: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
               end
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         missed_count <= '0;
      end else if (busy && adc_valid && above_thr && (missed_count != '1)) begin
         missed_count <= missed_count + CNT_ONE;
      end
   end

endmodule
`default_nettype wire
